fifo_rd_streamer: RTL

Read-side consumer stage placed directly downstream of the synchronous FIFO. It issues FIFO reads (rd_en), captures data_out one cycle later into a 2-entry skid buffer, and presents it as a valid/ready stream. Sustains 1 word/cycle with m_ready held high and the FIFO non-empty. Maintains a delivered-word counter and a sticky underflow error for coverage and debug.

---
 rtl/fifo_rd_streamer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for the synchronous FIFO: issues reads, lands data in a
// 2-entry skid buffer one cycle later, and presents it as a valid/ready stream.
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  err_underflow,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    skid_state_e           count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic                  capture;
    logic [1:0]            occupancy;

    assign pop     = (count_q != SKID_EMPTY) && m_ready;
    assign capture = inflight_q && !fifo_underflow;

    // Words held after this edge if nothing new is requested; a read is only
    // issued when its data is guaranteed a free slot on arrival.
    assign occupancy  = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd_en = !rst && !fifo_empty && (occupancy < 2'd2);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({capture, pop})
            2'b10: begin
                if (count_q == SKID_EMPTY) begin
                    head_d  = fifo_data_out;
                    count_d = SKID_ONE;
                end else begin
                    tail_d  = fifo_data_out;
                    count_d = SKID_TWO;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = (count_q == SKID_TWO) ? SKID_ONE : SKID_EMPTY;
            end
            2'b11: begin
                if (count_q == SKID_TWO) begin
                    head_d = tail_q;
                    tail_d = fifo_data_out;
                end else begin
                    head_d = fifo_data_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        word_cnt_d = pop ? word_cnt_q + CNT_WIDTH'(1) : word_cnt_q;
        if (inflight_q && fifo_underflow) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= SKID_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= fifo_rd_en;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    assign m_valid       = (count_q != SKID_EMPTY);
    assign m_data        = head_q;
    assign word_cnt      = word_cnt_q;
    assign err_underflow = err_q;

endmodule
